// File: rtl/pol_ofm_rsp_pkg.sv
// Shared definitions for the pooling Ofm responder: row geometry helpers and FSM encoding.
package pol_ofm_rsp_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRead = 1'b1
  } polState_e;

  function automatic int unsigned rowWidth(int unsigned actWidth, int unsigned compCore);
    return actWidth * compCore;
  endfunction

  function automatic int unsigned wordsPerRow(int unsigned actWidth, int unsigned compCore,
                                              int unsigned sramWidth);
    return rowWidth(actWidth, compCore) / sramWidth;
  endfunction

  // Index width that stays >= 1 for single-entry cases.
  function automatic int unsigned idxBits(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pol_ofm_rsp_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer, advances past the winner on accept.
module pol_ofm_rsp_rr_arb
  import pol_ofm_rsp_pkg::*;
#(
  parameter int unsigned NumReq = 6,
  parameter int unsigned IdxW   = idxBits(NumReq)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              softRst,
  input  logic [NumReq-1:0] req,
  input  logic              accept,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gntIdx,
  output logic              anyGnt
);

  logic [IdxW-1:0] ptrQ, ptrD;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    anyGnt = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      sum = {1'b0, ptrQ} + (IdxW + 1)'(off);
      if (sum >= (IdxW + 1)'(NumReq)) begin
        sum = sum - (IdxW + 1)'(NumReq);
      end
      cand = sum[IdxW-1:0];
      if (!anyGnt && req[cand]) begin
        anyGnt    = 1'b1;
        gnt[cand] = 1'b1;
        gntIdx    = cand;
      end
    end
  end

  always_comb begin
    ptrD = ptrQ;
    if (accept) begin
      ptrD = (gntIdx == IdxW'(NumReq - 1)) ? '0 : gntIdx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptrQ <= '0;
    end else if (softRst) begin
      ptrQ <= '0;
    end else begin
      ptrQ <= ptrD;
    end
  end

endmodule

// File: rtl/pol_ofm_rsp.sv
// GLB-side responder: arbitrates per-core Ofm row requests onto one SRAM read port and returns
// each assembled row to its core over a valid/ready channel.
module pol_ofm_rsp
  import pol_ofm_rsp_pkg::*;
#(
  parameter int unsigned IDX_WIDTH      = 10,
  parameter int unsigned ACT_WIDTH      = 8,
  parameter int unsigned POOL_COMP_CORE = 64,
  parameter int unsigned POOL_CORE      = 6,
  parameter int unsigned SRAM_WIDTH     = 256,
  parameter int unsigned ADDR_WIDTH     = 12
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     CCUGLB_Rst,
  input  logic [ADDR_WIDTH-1:0]                    CCUGLB_CfgBase,
  input  logic [POOL_CORE-1:0]                     POLGLB_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0]           POLGLB_Addr,
  output logic [POOL_CORE-1:0]                     GLBPOL_AddrRdy,
  output logic                                     GLBSRAM_RdEn,
  output logic [ADDR_WIDTH-1:0]                    GLBSRAM_RdAddr,
  input  logic [SRAM_WIDTH-1:0]                    SRAMGLB_RdDat,
  output logic [ACT_WIDTH*POOL_COMP_CORE*POOL_CORE-1:0] GLBPOL_Ofm,
  output logic [POOL_CORE-1:0]                     GLBPOL_OfmVld,
  input  logic [POOL_CORE-1:0]                     POLGLB_OfmRdy
);

  localparam int unsigned RowW  = rowWidth(ACT_WIDTH, POOL_COMP_CORE);
  localparam int unsigned Wpr   = wordsPerRow(ACT_WIDTH, POOL_COMP_CORE, SRAM_WIDTH);
  localparam int unsigned CoreW = idxBits(POOL_CORE);
  localparam int unsigned KW    = idxBits(Wpr);

  polState_e              stateQ, stateD;
  logic [CoreW-1:0]       coreQ;
  logic [IDX_WIDTH-1:0]   rowQ;
  logic [KW-1:0]          kQ;
  logic [POOL_CORE-1:0]   pendQ, ofmVldQ;
  logic [RowW*POOL_CORE-1:0] ofmQ;

  logic                   tagVldQ;
  logic [CoreW-1:0]       tagCoreQ;
  logic [KW-1:0]          tagKQ;

  logic [POOL_CORE-1:0]   freeSlot, eligible, gnt;
  logic [CoreW-1:0]       gntIdx;
  logic                   anyGnt, accept, lastWord, tagLast;
  logic [IDX_WIDTH-1:0]   reqRow;

  // A core may only request while it has neither a row in flight nor one waiting to be taken.
  assign freeSlot = ~ofmVldQ & ~pendQ;
  assign eligible = POLGLB_AddrVld & freeSlot;
  assign accept   = (stateQ == StIdle) & anyGnt & ~CCUGLB_Rst;
  assign lastWord = (kQ == KW'(Wpr - 1));
  assign tagLast  = (tagKQ == KW'(Wpr - 1));

  pol_ofm_rsp_rr_arb #(
    .NumReq (POOL_CORE),
    .IdxW   (CoreW)
  ) u_rr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .softRst (CCUGLB_Rst),
    .req     (eligible),
    .accept  (accept),
    .gnt     (gnt),
    .gntIdx  (gntIdx),
    .anyGnt  (anyGnt)
  );

  always_comb begin
    reqRow = '0;
    for (int i = 0; i < POOL_CORE; i++) begin
      if (gntIdx == CoreW'(i)) begin
        reqRow = POLGLB_Addr[IDX_WIDTH*i +: IDX_WIDTH];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (accept) stateD = StRead;
      StRead: if (lastWord) stateD = StIdle;
      default: stateD = StIdle;
    endcase
    if (CCUGLB_Rst) begin
      stateD = StIdle;
    end
  end

  // FSM: outputs
  always_comb begin
    GLBSRAM_RdEn   = 1'b0;
    GLBSRAM_RdAddr = '0;
    GLBPOL_AddrRdy = '0;
    if (stateQ == StRead) begin
      GLBSRAM_RdEn   = 1'b1;
      GLBSRAM_RdAddr = CCUGLB_CfgBase + ADDR_WIDTH'(rowQ * Wpr) + ADDR_WIDTH'(kQ);
    end
    if (accept) begin
      GLBPOL_AddrRdy = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coreQ    <= '0;
      rowQ     <= '0;
      kQ       <= '0;
      pendQ    <= '0;
      ofmVldQ  <= '0;
      ofmQ     <= '0;
      tagVldQ  <= 1'b0;
      tagCoreQ <= '0;
      tagKQ    <= '0;
    end else if (CCUGLB_Rst) begin
      // Clearing the tag drops whatever the SRAM returns for a read issued before the reset.
      coreQ    <= '0;
      rowQ     <= '0;
      kQ       <= '0;
      pendQ    <= '0;
      ofmVldQ  <= '0;
      ofmQ     <= '0;
      tagVldQ  <= 1'b0;
      tagCoreQ <= '0;
      tagKQ    <= '0;
    end else begin
      tagVldQ  <= GLBSRAM_RdEn;
      tagCoreQ <= coreQ;
      tagKQ    <= kQ;

      if (accept) begin
        coreQ <= gntIdx;
        rowQ  <= reqRow;
      end
      if (stateQ == StRead) begin
        kQ <= lastWord ? '0 : kQ + 1'b1;
      end

      for (int i = 0; i < POOL_CORE; i++) begin
        for (int k = 0; k < Wpr; k++) begin
          if (tagVldQ && tagCoreQ == CoreW'(i) && tagKQ == KW'(k)) begin
            ofmQ[RowW*i + SRAM_WIDTH*k +: SRAM_WIDTH] <= SRAMGLB_RdDat;
          end
        end
        if (tagVldQ && tagLast && tagCoreQ == CoreW'(i)) begin
          pendQ[i]   <= 1'b0;
          ofmVldQ[i] <= 1'b1;
        end else if (ofmVldQ[i] && POLGLB_OfmRdy[i]) begin
          ofmVldQ[i] <= 1'b0;
        end
        if (accept && gnt[i]) begin
          pendQ[i] <= 1'b1;
        end
      end
    end
  end

  assign GLBPOL_Ofm    = ofmQ;
  assign GLBPOL_OfmVld = ofmVldQ;

endmodule

// File: tb/tb_pol_ofm_rsp.sv
// Scoreboard bench for pol_ofm_rsp: expected read addresses and rows are queued at issue time and
// checked by a monitor whenever the DUT reads SRAM or hands a row back.
module tb_pol_ofm_rsp;

  localparam int unsigned IdxWidth = 10;

  typedef struct {
    int          core;
    logic [511:0] row;
  } rowExp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CCUGLB_Rst = 1'b0;
  logic [11:0]   CCUGLB_CfgBase = 12'h100;
  logic [5:0]    POLGLB_AddrVld = '0;
  logic [59:0]   POLGLB_Addr = '0;
  logic [5:0]    GLBPOL_AddrRdy;
  logic          GLBSRAM_RdEn;
  logic [11:0]   GLBSRAM_RdAddr;
  logic [255:0]  SRAMGLB_RdDat = '0;
  logic [3071:0] GLBPOL_Ofm;
  logic [5:0]    GLBPOL_OfmVld;
  logic [5:0]    POLGLB_OfmRdy = '1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mFound;
  rowExp_t     rowExp[$];
  logic [11:0] addrExp[$];
  int          accCore[$];
  int          accCyc[$];

  pol_ofm_rsp u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .CCUGLB_Rst     (CCUGLB_Rst),
    .CCUGLB_CfgBase (CCUGLB_CfgBase),
    .POLGLB_AddrVld (POLGLB_AddrVld),
    .POLGLB_Addr    (POLGLB_Addr),
    .GLBPOL_AddrRdy (GLBPOL_AddrRdy),
    .GLBSRAM_RdEn   (GLBSRAM_RdEn),
    .GLBSRAM_RdAddr (GLBSRAM_RdAddr),
    .SRAMGLB_RdDat  (SRAMGLB_RdDat),
    .GLBPOL_Ofm     (GLBPOL_Ofm),
    .GLBPOL_OfmVld  (GLBPOL_OfmVld),
    .POLGLB_OfmRdy  (POLGLB_OfmRdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] sramWord(logic [11:0] a);
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[32*j +: 32] = {a, 4'(j), 16'hC0DE};
    return w;
  endfunction

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (GLBSRAM_RdEn) SRAMGLB_RdDat <= sramWord(GLBSRAM_RdAddr);
  end

  task automatic check(string name, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pushExp(int core, int row, logic [11:0] base);
    logic [11:0] a0;
    logic [11:0] a1;
    rowExp_t     e;
    a0 = base + 12'(2 * row);
    a1 = a0 + 12'd1;
    addrExp.push_back(a0);
    addrExp.push_back(a1);
    e.core = core;
    e.row  = {sramWord(a1), sramWord(a0)};
    rowExp.push_back(e);
  endtask

  // Holds a request until the handshake, then drops it; returns at #1 after the accepting edge.
  task automatic drive(int core, int row);
    bit done;
    done = 1'b0;
    POLGLB_Addr[IdxWidth*core +: IdxWidth] = IdxWidth'(row);
    POLGLB_AddrVld[core] = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = GLBPOL_AddrRdy[core];
      @(posedge clk);
      #1;
    end
    POLGLB_AddrVld[core] = 1'b0;
    if (!done) check("accept_timeout", 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 6; i++) begin
        if (POLGLB_AddrVld[i] && GLBPOL_AddrRdy[i]) begin
          accCore.push_back(i);
          accCyc.push_back(cyc);
        end
      end
      if (GLBSRAM_RdEn) begin
        if (addrExp.size() == 0) check("rd_unexpected", GLBSRAM_RdEn, 1'b0);
        else check("rd_addr", GLBSRAM_RdAddr, addrExp.pop_front());
      end
      for (int i = 0; i < 6; i++) begin
        if (GLBPOL_OfmVld[i] && POLGLB_OfmRdy[i]) begin
          mFound = -1;
          for (int j = 0; j < rowExp.size(); j++) begin
            if (mFound < 0 && rowExp[j].core == i) mFound = j;
          end
          if (mFound < 0) begin
            check("ofm_unexpected_vld", GLBPOL_OfmVld[i], 1'b0);
          end else begin
            check("ofm_row", GLBPOL_Ofm[512*i +: 512], rowExp[mFound].row);
            rowExp.delete(mFound);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base0;
    bit sawRdy1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr_rdy", GLBPOL_AddrRdy, 6'd0);
    check("rst_rden", GLBSRAM_RdEn, 1'b0);
    check("rst_rdaddr", GLBSRAM_RdAddr, 12'd0);
    check("rst_ofm_vld", GLBPOL_OfmVld, 6'd0);
    check("rst_ofm_zero", |GLBPOL_Ofm, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single request, address sequence and latency
    pushExp(2, 5, 12'h100);
    drive(2, 5);
    t = accCyc.size();
    check("t1_acc_core", accCore[t-1], 2);
    @(negedge clk);
    check("t1_rden_w0", GLBSRAM_RdEn, 1'b1);
    check("t1_addr_w0", GLBSRAM_RdAddr, 12'h10A);
    @(negedge clk);
    check("t1_addr_w1", GLBSRAM_RdAddr, 12'h10B);
    @(negedge clk);
    check("t1_vld_early", GLBPOL_OfmVld[2], 1'b0);
    @(negedge clk);
    check("t1_vld_t4", GLBPOL_OfmVld[2], 1'b1);
    check("t1_ofm", GLBPOL_Ofm[1024 +: 512], {sramWord(12'h10B), sramWord(12'h10A)});
    repeat (4) @(posedge clk);

    // 2: soft reset restores pointer; all six cores served in order, one per 3 cycles
    #1 CCUGLB_Rst = 1'b1;
    @(posedge clk);
    #1 CCUGLB_Rst = 1'b0;
    base0 = accCore.size();
    for (int i = 0; i < 6; i++) pushExp(i, 10 + i, 12'h100);
    fork
      drive(0, 10);
      drive(1, 11);
      drive(2, 12);
      drive(3, 13);
      drive(4, 14);
      drive(5, 15);
    join
    for (int i = 0; i < 6; i++) check("t2_order", accCore[base0+i], i);
    for (int i = 1; i < 6; i++) check("t2_spacing", accCyc[base0+i] - accCyc[base0+i-1], 3);
    repeat (10) @(posedge clk);
    #1;

    // 3: core1 holds its row; its re-request waits while cores 2 and 0 are served
    POLGLB_OfmRdy[1] = 1'b0;
    pushExp(1, 20, 12'h100);
    drive(1, 20);
    for (int n = 0; n < 20 && !GLBPOL_OfmVld[1]; n++) @(negedge clk);
    check("t3_hold_vld", GLBPOL_OfmVld[1], 1'b1);
    @(posedge clk);
    #1;
    base0 = accCore.size();
    pushExp(2, 30, 12'h100);
    pushExp(0, 31, 12'h100);
    pushExp(1, 21, 12'h100);
    fork
      drive(2, 30);
      drive(0, 31);
      drive(1, 21);
      begin
        sawRdy1 = 1'b0;
        repeat (12) begin
          @(negedge clk);
          if (GLBPOL_AddrRdy[1]) sawRdy1 = 1'b1;
        end
        check("t3_core1_blocked", sawRdy1, 1'b0);
        check("t3_first", accCore[base0], 2);
        check("t3_second", accCore[base0+1], 0);
        check("t3_still_vld", GLBPOL_OfmVld[1], 1'b1);
        @(posedge clk);
        #1 POLGLB_OfmRdy[1] = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // 6: return handshake and re-request in the same cycle
    POLGLB_OfmRdy[3] = 1'b0;
    pushExp(3, 40, 12'h100);
    drive(3, 40);
    for (int n = 0; n < 20 && !GLBPOL_OfmVld[3]; n++) @(negedge clk);
    check("t6_hold_vld", GLBPOL_OfmVld[3], 1'b1);
    @(posedge clk);
    #1;
    pushExp(3, 41, 12'h100);
    POLGLB_Addr[30 +: 10] = 10'd41;
    POLGLB_AddrVld[3] = 1'b1;
    POLGLB_OfmRdy[3]  = 1'b1;
    @(negedge clk);
    check("t6_rdy_same_cycle", GLBPOL_AddrRdy[3], 1'b0);
    @(negedge clk);
    check("t6_rdy_next_cycle", GLBPOL_AddrRdy[3], 1'b1);
    @(posedge clk);
    #1 POLGLB_AddrVld[3] = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // 4: soft reset during word0 issue discards the in-flight read
    addrExp.push_back(12'h10E);
    drive(4, 7);
    CCUGLB_Rst = 1'b1;
    @(negedge clk);
    check("t4_rden_w0", GLBSRAM_RdEn, 1'b1);
    @(posedge clk);
    #1 CCUGLB_Rst = 1'b0;
    @(negedge clk);
    check("t4_rden_drop", GLBSRAM_RdEn, 1'b0);
    check("t4_vld_clear", GLBPOL_OfmVld, 6'd0);
    @(negedge clk);
    check("t4_ofm_zero", |GLBPOL_Ofm, 1'b0);
    @(negedge clk);
    check("t4_ofm_zero_late", |GLBPOL_Ofm, 1'b0);
    check("t4_vld_still_clear", GLBPOL_OfmVld, 6'd0);
    @(posedge clk);
    #1;

    // 5: address wraps modulo 4096
    CCUGLB_CfgBase = 12'hFFE;
    pushExp(4, 1, 12'hFFE);
    drive(4, 1);
    @(negedge clk);
    check("t5_addr_w0", GLBSRAM_RdAddr, 12'h000);
    @(negedge clk);
    check("t5_addr_w1", GLBSRAM_RdAddr, 12'h001);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("addr_queue_empty", addrExp.size(), 0);
    check("row_queue_empty", rowExp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
